// File: rtl/soi_access_ctrl_pkg.sv
// soi_pkg: shared types and constants for the SOI access controller.
//   soi_state_t : controller FSM states
//   SOI_STAT_W  : width of each per-requester completion counter
//   soi_req_t   : latched access request (write, data, hold); fields are
//                 sized to the largest supported DATA_W / HOLD_W and the
//                 unused upper bits are tied to zero by the controller.
package soi_pkg;
  localparam int SOI_STAT_W     = 16;
  localparam int SOI_MAX_DATA_W = 32;
  localparam int SOI_MAX_HOLD_W = 16;

  typedef enum logic [1:0] {IDLE, EXEC, HOLD, RESP} soi_state_t;

  typedef struct packed {
    logic                      write;
    logic [SOI_MAX_DATA_W-1:0] data;
    logic [SOI_MAX_HOLD_W-1:0] hold;
  } soi_req_t;
endpackage

// File: rtl/soi_access_ctrl_if.sv
// soi_access_ctrl_if: host request / response bus of the SOI controller.
//   req_valid/req_ready/req_write : per-requester handshake, one bit each
//   req_data/req_hold              : packed per-requester write data / hold
//   rsp_valid/rsp_id/rsp_data      : single completion channel
// master = host side, slave = controller side.
interface soi_access_ctrl_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8,
  parameter int HOLD_W  = 4
);
  localparam int ID_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ-1:0]        req_write;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ*HOLD_W-1:0] req_hold;
  logic                      rsp_valid;
  logic [ID_W-1:0]           rsp_id;
  logic [DATA_W-1:0]         rsp_data;

  modport master (
    output req_valid, req_write, req_data, req_hold,
    input  req_ready, rsp_valid, rsp_id, rsp_data
  );

  modport slave (
    input  req_valid, req_write, req_data, req_hold,
    output req_ready, rsp_valid, rsp_id, rsp_data
  );
endinterface

// File: rtl/soi_access_ctrl_rr_arbiter.sv
// soi_rr_arbiter: combinational round-robin grant.
//   req        : request vector
//   last_grant : id granted last; search starts at last_grant+1 and wraps
//   gnt        : one-hot grant (all zero when no request)
//   gnt_id     : encoded id of the granted requester
module soi_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    last_grant,
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_W-1:0]    gnt_id
);
  always_comb begin : arb
    int  idx;
    logic found;
    gnt    = '0;
    gnt_id = '0;
    found  = 1'b0;
    idx    = 0;
    // k = NUM_REQ lands back on last_grant, giving it lowest priority
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(last_grant) + k) % NUM_REQ;
      if (!found && req[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        gnt_id   = idx[ID_W-1:0];
      end
    end
  end
endmodule

// File: rtl/soi_access_ctrl.sv
// soi_access_ctrl: round-robin sequencer for a shared, free-running SOI
// register. The register inverts every cycle while run_en is high; one
// read or write access is served at a time. A write forces the register
// for hold+1 cycles before free-running resumes.
//   clk, rst : clock, synchronous active-high reset
//   run_en   : free-run enable
//   bus      : request/response bus (slave side)
//   soi_q    : observed SOI register
//   busy     : FSM not in IDLE
//   stat_cnt : per-requester completion counters (only with SOI_STATS_EN)
// Optional feature macro: SOI_STATS_EN.
module soi_access_ctrl
  import soi_pkg::*;
#(
  parameter int                NUM_REQ  = 4,
  parameter int                DATA_W   = 8,   // <= SOI_MAX_DATA_W
  parameter int                HOLD_W   = 4,   // <= SOI_MAX_HOLD_W
  parameter logic [DATA_W-1:0] INIT_VAL = '1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               run_en,
  soi_access_ctrl_if.slave   bus,
  output logic [DATA_W-1:0]  soi_q,
`ifdef SOI_STATS_EN
  output logic [NUM_REQ*SOI_STAT_W-1:0] stat_cnt,
`endif
  output logic               busy
);
  localparam int ID_W = $clog2(NUM_REQ);

  soi_state_t          state_q, state_d;
  soi_req_t            req_q, req_d;
  logic [ID_W-1:0]     id_q, id_d, last_q, last_d;
  logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;
  logic [DATA_W-1:0]   soi_d, rsp_data_q, rsp_data_d;
  logic [NUM_REQ-1:0]  gnt;
  logic [ID_W-1:0]     gnt_id;
  logic [DATA_W-1:0]   wr_data;
  logic [HOLD_W-1:0]   wr_hold;
  logic                unused_req;

  soi_rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_arb (
    .req        (bus.req_valid),
    .last_grant (last_q),
    .gnt        (gnt),
    .gnt_id     (gnt_id)
  );

  assign wr_data    = req_q.data[DATA_W-1:0];
  assign wr_hold    = req_q.hold[HOLD_W-1:0];
  assign unused_req = ^req_q;  // upper struct bits are always zero

  // Gated with rst so nothing is offered or answered in a reset cycle.
  assign bus.req_ready = (state_q == IDLE && !rst) ? gnt : '0;
  assign bus.rsp_valid = (state_q == RESP) && !rst;
  assign bus.rsp_id    = id_q;
  assign bus.rsp_data  = rsp_data_q;
  assign busy          = (state_q != IDLE);

  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    id_d       = id_q;
    last_d     = last_q;
    hold_cnt_d = hold_cnt_q;
    rsp_data_d = rsp_data_q;
    soi_d      = run_en ? ~soi_q : soi_q;
    case (state_q)
      IDLE: begin
        if (|gnt) begin
          id_d                    = gnt_id;
          last_d                  = gnt_id;
          req_d                   = '0;
          req_d.write             = bus.req_write[gnt_id];
          req_d.data[DATA_W-1:0]  = bus.req_data[gnt_id*DATA_W +: DATA_W];
          req_d.hold[HOLD_W-1:0]  = bus.req_hold[gnt_id*HOLD_W +: HOLD_W];
          state_d                 = EXEC;
        end
      end
      EXEC: begin
        if (req_q.write) begin
          soi_d      = wr_data;
          rsp_data_d = wr_data;
          if (wr_hold == '0) begin
            state_d = RESP;
          end else begin
            hold_cnt_d = wr_hold;
            state_d    = HOLD;
          end
        end else begin
          rsp_data_d = soi_q;  // value before this cycle's inversion
          state_d    = RESP;
        end
      end
      HOLD: begin
        soi_d      = soi_q;
        hold_cnt_d = hold_cnt_q - 1'b1;
        if (hold_cnt_q == HOLD_W'(1)) state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      req_q      <= '0;
      id_q       <= '0;
      last_q     <= ID_W'(NUM_REQ-1);
      hold_cnt_q <= '0;
      rsp_data_q <= '0;
      soi_q      <= INIT_VAL;
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      id_q       <= id_d;
      last_q     <= last_d;
      hold_cnt_q <= hold_cnt_d;
      rsp_data_q <= rsp_data_d;
      soi_q      <= soi_d;
    end
  end

`ifdef SOI_STATS_EN
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_stat
    logic [SOI_STAT_W-1:0] cnt_q, cnt_d;
    always_comb begin
      cnt_d = cnt_q;
      if (state_q == RESP && id_q == ID_W'(i) && cnt_q != '1)
        cnt_d = cnt_q + 1'b1;
    end
    always_ff @(posedge clk) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
    end
    assign stat_cnt[i*SOI_STAT_W +: SOI_STAT_W] = cnt_q;
  end
`endif
endmodule

// File: tb/tb_soi_access_ctrl.sv
// tb_soi_access_ctrl: directed self-checking bench for soi_access_ctrl with
// a response scoreboard (expected {id,data} pushed at request time, popped
// by a monitor on rsp_valid). Defaults: NUM_REQ=4, DATA_W=8, HOLD_W=4.
module tb_soi_access_ctrl;
  typedef struct { int id; logic [7:0] d; } exp_t;

  logic clk = 1'b0;
  logic rst, run_en;
  logic [7:0] soi_q;
  logic busy;
`ifdef SOI_STATS_EN
  logic [63:0] stat_cnt;
`endif

  int   n_chk  = 0;
  int   n_fail = 0;
  exp_t sb[$];
  logic [7:0] hist [0:23];

  always #5 clk = ~clk;

  soi_access_ctrl_if #(.NUM_REQ(4), .DATA_W(8), .HOLD_W(4)) bus ();

  soi_access_ctrl #(.NUM_REQ(4), .DATA_W(8), .HOLD_W(4), .INIT_VAL(8'hFF)) dut (
    .clk    (clk),
    .rst    (rst),
    .run_en (run_en),
    .bus    (bus),
    .soi_q  (soi_q),
`ifdef SOI_STATS_EN
    .stat_cnt (stat_cnt),
`endif
    .busy   (busy)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (!rst && bus.rsp_valid === 1'b1) begin
      if (sb.size() == 0) begin
        chk("rsp_unexp", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("rsp_id",   32'(bus.rsp_id), e.id);
        chk("rsp_data", 32'(bus.rsp_data), 32'(e.d));
      end
    end
  end

  // Called at a negedge with the DUT in IDLE; returns at the RESP negedge.
  task automatic access(input int id, input bit wr, input logic [7:0] d,
                        input logic [3:0] h, input logic [7:0] exp_d,
                        input int exp_lat);
    int n;
    logic [3:0] oh;
    oh = 4'b0001 << id;
    bus.req_valid[id]       = 1'b1;
    bus.req_write[id]       = wr;
    bus.req_data[id*8 +: 8] = d;
    bus.req_hold[id*4 +: 4] = h;
    sb.push_back('{id, exp_d});
    #1 chk("ready_onehot", 32'(bus.req_ready), 32'(oh));
    @(posedge clk);
    #1 bus.req_valid[id] = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      hist[n] = soi_q;
    end while (bus.rsp_valid !== 1'b1 && n < 20);
    chk("rsp_latency", n, exp_lat);
  endtask

  initial begin
    int n_acc, cyc, gid;
    int acc_id [0:4];
    int acc_cyc[0:4];

    rst = 1'b1; run_en = 1'b1;
    bus.req_valid = '0; bus.req_write = '0; bus.req_data = '0; bus.req_hold = '0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_soi",      soi_q, 8'hFF);
    chk("rst_busy",     busy, 0);
    chk("rst_rsp_vld",  bus.rsp_valid, 0);
    chk("rst_rsp_id",   bus.rsp_id, 0);
    chk("rst_rsp_data", bus.rsp_data, 0);
    chk("rst_ready",    bus.req_ready, 0);
    rst = 1'b0;

    // Free-run toggle
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("freerun_soi", soi_q, (i % 2 == 0) ? 8'h00 : 8'hFF);
      chk("freerun_busy", busy, 0);
    end

    // Read by requester 2 with soi = 00 during EXEC
    for (int i = 0; i < 4 && soi_q !== 8'hFF; i++) @(negedge clk);
    access(2, 1'b0, 8'h00, 4'd0, 8'h00, 2);

    // Write A5 hold 3 by requester 1
    @(negedge clk);
    access(1, 1'b1, 8'hA5, 4'd3, 8'hA5, 5);
    for (int k = 2; k <= 5; k++) chk("hold_soi", hist[k], 8'hA5);
    @(negedge clk);
    chk("hold_resume", soi_q, 8'h5A);

    // run_en low: SOI frozen, accesses still work
    run_en = 1'b0;
    @(negedge clk);
    chk("frozen_soi", soi_q, 8'h5A);
    access(3, 1'b0, 8'h00, 4'd0, 8'h5A, 2);
    @(negedge clk);
    access(0, 1'b1, 8'h3C, 4'd0, 8'h3C, 2);
    chk("frozen_wr", soi_q, 8'h3C);
    @(negedge clk);
    chk("frozen_wr2", soi_q, 8'h3C);
    run_en = 1'b1;

    // Continuous contention from reset
    rst = 1'b1;
    bus.req_valid = 4'hF; bus.req_write = 4'hF;
    bus.req_data = 32'h13121110; bus.req_hold = '0;
    repeat (2) @(negedge clk);
    chk("rst_ready_contend", bus.req_ready, 0);
    rst = 1'b0;
    #1;
    n_acc = 0; cyc = 0;
    while (n_acc < 5 && cyc < 60) begin
      if (|(bus.req_valid & bus.req_ready)) begin
        gid = 0;
        for (int j = 0; j < 4; j++) if (bus.req_ready[j]) gid = j;
        acc_id[n_acc]  = gid;
        acc_cyc[n_acc] = cyc;
        sb.push_back('{gid, 8'h10 + 8'(gid)});
        n_acc++;
      end
      @(negedge clk); #1;
      cyc++;
    end
    bus.req_valid = '0;
    chk("acc_count", n_acc, 5);
    for (int k = 0; k < n_acc; k++) begin
      chk("rr_order", acc_id[k], k % 4);
      if (k > 0) chk("acc_spacing", acc_cyc[k] - acc_cyc[k-1], 3);
    end
    repeat (6) @(negedge clk);
    chk("sb_drain", sb.size(), 0);

    // Reset during HOLD of a hold=5 write: no response expected
    @(negedge clk);
    bus.req_valid[0] = 1'b1; bus.req_write[0] = 1'b1;
    bus.req_data[7:0] = 8'h77; bus.req_hold[3:0] = 4'd5;
    @(posedge clk);
    #1 bus.req_valid[0] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("midhold_soi", soi_q, 8'h77);
    chk("midhold_busy", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_busy", busy, 0);
    chk("abort_soi", soi_q, 8'hFF);
    chk("abort_rsp", bus.rsp_valid, 0);
    rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("abort_norsp", bus.rsp_valid, 0);
    end

`ifdef SOI_STATS_EN
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      access(3, 1'b1, 8'(k), 4'd0, 8'(k), 2);
    end
    @(negedge clk);
    chk("stat_r3", stat_cnt[63:48], 3);
    chk("stat_r2", stat_cnt[47:32], 0);
    chk("stat_r1", stat_cnt[31:16], 0);
    chk("stat_r0", stat_cnt[15:0],  0);
`endif

    repeat (3) @(negedge clk);
    chk("sb_final", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
